// File: rtl/vram_write_arbiter_if.sv
// Requester-side bus of the VRAM write arbiter: two write masters with
// request/last/address/data in, one-hot grant out (names seen from the arbiter).
interface vram_write_arbiter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 1
);
    logic [1:0]            req_i;
    logic [1:0]            last_i;
    logic [ADDR_WIDTH-1:0] addr0_i;
    logic [ADDR_WIDTH-1:0] addr1_i;
    logic [DATA_WIDTH-1:0] data0_i;
    logic [DATA_WIDTH-1:0] data1_i;
    logic [1:0]            gnt_o;

    modport slave (
        input  req_i, last_i, addr0_i, addr1_i, data0_i, data1_i,
        output gnt_o
    );

    modport master (
        output req_i, last_i, addr0_i, addr1_i, data0_i, data1_i,
        input  gnt_o
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Two-master VRAM write-port arbiter with bounded bursts and registered writes.
// Define VRAM_ARB_FIXED_PRIO_EN to pin tie priority to requester 0 (default: round-robin).
module vram_write_arbiter #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int MAX_BURST      = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    vram_write_arbiter_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] vram_write_address_o,
    output logic [DATA_WIDTH-1:0] vram_write_data_o,
    output logic                  vram_write_ena_o,
    output logic                  oor_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int                  CNT_W       = $clog2(MAX_BURST+1);
    localparam logic [CNT_W-1:0]    BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [ADDR_WIDTH:0] FRAME_CELLS = (ADDR_WIDTH+1)'(ACTIVE_COLUMNS*ACTIVE_ROWS);

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ena_q, ena_d;
    logic                  oor_q, oor_d;

    logic                  granted;
    logic                  owner;
    logic                  other;
    logic                  beat;
    logic                  in_range;
    logic                  release_now;
    logic [CNT_W-1:0]      cnt_inc;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [DATA_WIDTH-1:0] beat_data;

    always_comb begin
        granted   = (state_q != IDLE);
        owner     = (state_q == GRANT1);
        other     = ~owner;
        beat      = granted & bus.req_i[owner];
        beat_addr = owner ? bus.addr1_i : bus.addr0_i;
        beat_data = owner ? bus.data1_i : bus.data0_i;
        in_range  = ({1'b0, beat_addr} < FRAME_CELLS);
        cnt_inc   = cnt_q + CNT_W'(1);
        // Dropping req while granted releases without a beat; otherwise the beat
        // itself releases on last or when it fills the burst window.
        release_now = granted & (~bus.req_i[owner] | bus.last_i[owner] | (cnt_inc == BURST_LIMIT));
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                case (bus.req_i)
                    2'b01:   state_d = GRANT0;
                    2'b10:   state_d = GRANT1;
                    2'b11:   state_d = prio_q ? GRANT1 : GRANT0;
                    default: state_d = IDLE;
                endcase
            end
            GRANT0, GRANT1: begin
                if (release_now) begin
                    cnt_d = '0;
`ifdef VRAM_ARB_FIXED_PRIO_EN
                    prio_d = 1'b0;
`else
                    prio_d = other;
`endif
                    if (bus.req_i[other]) begin
                        state_d = other ? GRANT1 : GRANT0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every beat is registered; out-of-range beats raise oor instead of the enable.
    always_comb begin
        ena_d  = beat & in_range;
        oor_d  = beat & ~in_range;
        addr_d = beat ? beat_addr : addr_q;
        data_d = beat ? beat_data : data_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ena_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
            oor_q   <= oor_d;
        end
    end

    assign bus.gnt_o            = {state_q == GRANT1, state_q == GRANT0};
    assign busy_o               = (state_q != IDLE);
    assign vram_write_address_o = addr_q;
    assign vram_write_data_o    = data_q;
    assign vram_write_ena_o     = ena_q;
    assign oor_o                = oor_q;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: directed scenarios plus random
// traffic, all checked each cycle against a queue-based behavioural model.
module tb_vram_write_arbiter;
    localparam int AW    = 19;
    localparam int MAXB  = 4;
    localparam int FRAME = 640*480;
`ifdef VRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        bit            idle;
        logic [AW-1:0] addr;
        logic          data;
        bit            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] vram_addr;
    logic [0:0]    vram_data;
    logic          vram_ena;
    logic          oor;
    logic          busy;

    vram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(1)) bus ();

    vram_write_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk_i               (clk),
        .reset_i             (rst),
        .bus                 (bus),
        .vram_write_address_o(vram_addr),
        .vram_write_data_o   (vram_data),
        .vram_write_ena_o    (vram_ena),
        .oor_o               (oor),
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t mq0[$];
    beat_t mq1[$];

    // model state: current owner (-1 none), beats in this grant, tie winner
    int            own = -1;
    int            nb = 0;
    int            pr = 0;
    bit            e_ena = 0;
    bit            e_oor = 0;
    logic [AW-1:0] e_addr = '0;
    logic          e_data = 1'b0;

    int            gl_k[$];
    int            gl_n[$];
    int            wlog[$];
    int            wdlog[$];
    int            oor_cnt, busy_cnt, first_busy, last_busy, req_rise0, gnt_rise0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        gl_k.delete(); gl_n.delete(); wlog.delete(); wdlog.delete();
        oor_cnt = 0; busy_cnt = 0; first_busy = -1; last_busy = -1;
        req_rise0 = -1; gnt_rise0 = -1;
    endtask

    task automatic model_reset();
        own = -1; nb = 0; pr = 0;
        e_ena = 0; e_oor = 0; e_addr = '0; e_data = 1'b0;
    endtask

    task automatic model_step();
        int k;
        int o;
        bit rel;
        logic [AW-1:0] a;
        e_ena = 0;
        e_oor = 0;
        if (own < 0) begin
            if (bus.req_i == 2'b11) own = pr;
            else if (bus.req_i[0]) own = 0;
            else if (bus.req_i[1]) own = 1;
        end else begin
            k = own;
            o = 1 - k;
            rel = 0;
            if (!bus.req_i[k]) begin
                rel = 1;
            end else begin
                a = (k == 0) ? bus.addr0_i : bus.addr1_i;
                if (a < FRAME) begin
                    e_ena = 1;
                    e_addr = a;
                    e_data = (k == 0) ? bus.data0_i[0] : bus.data1_i[0];
                end else begin
                    e_oor = 1;
                end
                nb++;
                if (bus.last_i[k] || nb == MAXB) rel = 1;
            end
            if (rel) begin
                gl_k.push_back(k);
                gl_n.push_back(nb);
                nb = 0;
                pr = FIXED ? 0 : o;
                own = bus.req_i[o] ? o : -1;
            end
        end
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : compare_proc
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("gnt", bus.gnt_o, (own < 0) ? 0 : ((own == 0) ? 1 : 2));
            chk("busy", busy, (own >= 0));
            chk("ena", vram_ena, e_ena);
            chk("oor", oor, e_oor);
            if (e_ena) begin
                chk("addr", vram_addr, e_addr);
                chk("data", vram_data, e_data);
            end
            if (vram_ena) begin
                wlog.push_back(int'(vram_addr));
                wdlog.push_back(int'(vram_data));
            end
            if (oor) oor_cnt++;
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end
            if (bus.gnt_o[0] && gnt_rise0 < 0) gnt_rise0 = cyc;
        end
    end

    initial begin : driver
        bit acc0;
        bit acc1;
        bus.req_i = 2'b00; bus.last_i = 2'b00;
        bus.addr0_i = '0; bus.addr1_i = '0; bus.data0_i = '0; bus.data1_i = '0;
        forever begin
            @(negedge clk);
            acc0 = 0;
            acc1 = 0;
            if (mq0.size() > 0) acc0 = mq0[0].idle || (bus.gnt_o[0] && bus.req_i[0]);
            if (mq1.size() > 0) acc1 = mq1[0].idle || (bus.gnt_o[1] && bus.req_i[1]);
            @(posedge clk);
            #2;
            if (!rst) begin
                if (acc0 && mq0.size() > 0) void'(mq0.pop_front());
                if (acc1 && mq1.size() > 0) void'(mq1.pop_front());
            end
            if (mq0.size() > 0 && !mq0[0].idle) begin
                bus.req_i[0] = 1'b1; bus.last_i[0] = mq0[0].last;
                bus.addr0_i = mq0[0].addr; bus.data0_i = mq0[0].data;
            end else begin
                bus.req_i[0] = 1'b0; bus.last_i[0] = 1'b0;
            end
            if (mq1.size() > 0 && !mq1[0].idle) begin
                bus.req_i[1] = 1'b1; bus.last_i[1] = mq1[0].last;
                bus.addr1_i = mq1[0].addr; bus.data1_i = mq1[0].data;
            end else begin
                bus.req_i[1] = 1'b0; bus.last_i[1] = 1'b0;
            end
            if (bus.req_i[0] && req_rise0 < 0) req_rise0 = cyc;
        end
    end

    task automatic add(input int m, input bit idle, input int a, input bit d, input bit l);
        beat_t b;
        b.idle = idle;
        b.addr = AW'(a);
        b.data = d;
        b.last = l;
        if (m == 0) mq0.push_back(b);
        else mq1.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        mq0.delete(); mq1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int n = 0;
        while ((mq0.size() > 0 || mq1.size() > 0 || bus.gnt_o != 2'b00) && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_drain_timeout"}, (n >= lim), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_glog(input string nm, input int ek[$], input int en[$]);
        chk({nm, "_grants"}, gl_k.size(), ek.size());
        for (int i = 0; i < ek.size() && i < gl_k.size(); i++) begin
            chk($sformatf("%s_grant%0d_req", nm, i), gl_k[i], ek[i]);
            chk($sformatf("%s_grant%0d_beats", nm, i), gl_n[i], en[i]);
        end
    endtask

    task automatic chk_wlog(input string nm, input int ea[$]);
        chk({nm, "_writes"}, wlog.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wlog.size(); i++)
            chk($sformatf("%s_write%0d_addr", nm, i), wlog[i], ea[i]);
    endtask

    initial begin : main
        int sel0[$];
        bit found;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ena", vram_ena, 0);
        chk("rst_oor", oor, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_data", vram_data, 0);

        // single requester, 4 beats
        do_reset();
        for (int i = 0; i < 4; i++) add(0, 0, i, 1, (i == 3));
        wait_drain("single", 200);
        chk_glog("single", {0}, {4});
        chk_wlog("single", {0, 1, 2, 3});
        chk("single_data_sum", wdlog.sum(), 4);
        chk("single_req_to_gnt", gnt_rise0 - req_rise0, 1);
        chk("single_gnt_after", bus.gnt_o, 0);

        // simultaneous requests, zero-cycle handover
        do_reset();
        add(0, 0, 10, 1, 0); add(0, 0, 11, 1, 1); add(0, 0, 12, 1, 0); add(0, 0, 13, 1, 1);
        add(1, 0, 20, 0, 0); add(1, 0, 21, 0, 1); add(1, 0, 22, 0, 0); add(1, 0, 23, 0, 1);
        wait_drain("tie", 300);
        chk_glog("tie", {0, 1, 0, 1}, {2, 2, 2, 2});
        chk_wlog("tie", {10, 11, 20, 21, 12, 13, 22, 23});
        chk("tie_busy_cycles", busy_cnt, 8);
        chk("tie_busy_span", last_busy - first_busy + 1, 8);

        // tie from IDLE after requester 0 was last served
        do_reset();
        add(0, 0, 30, 1, 1); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);
        add(0, 0, 31, 1, 1);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0);
        add(1, 0, 40, 0, 1);
        wait_drain("prio", 300);
        if (FIXED) begin
            chk_glog("prio", {0, 0, 1}, {1, 1, 1});
            chk_wlog("prio", {30, 31, 40});
        end else begin
            chk_glog("prio", {0, 1, 0}, {1, 1, 1});
            chk_wlog("prio", {30, 40, 31});
        end

        // forced release at MAX_BURST
        do_reset();
        for (int i = 0; i < 10; i++) add(0, 0, 100 + i, i[0], 0);
        add(1, 0, 500, 0, 1); add(1, 0, 500, 0, 1);
        wait_drain("forced", 300);
        chk_glog("forced", {0, 1, 0, 1, 0}, {4, 1, 4, 1, 2});
        chk("forced_total_writes", wlog.size(), 12);
        sel0.delete();
        foreach (wlog[i]) if (wlog[i] >= 100 && wlog[i] < 110) sel0.push_back(wlog[i]);
        wlog = sel0;
        chk_wlog("forced_req0", {100, 101, 102, 103, 104, 105, 106, 107, 108, 109});

        // out-of-range beats
        do_reset();
        add(0, 0, FRAME, 1, 0); add(0, 0, (1 << AW) - 1, 1, 0); add(0, 0, 5, 1, 1);
        wait_drain("oor", 200);
        chk("oor_pulses", oor_cnt, 2);
        chk_wlog("oor", {5});
        chk_glog("oor", {0}, {3});

        // reset during beat 3 of 5
        do_reset();
        for (int i = 0; i < 5; i++) add(0, 0, 200 + i, 1, (i == 4));
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(posedge clk); #3;
            if (mq0.size() == 3 && bus.gnt_o[0]) found = 1;
        end
        chk("midrst_found_beat3", found, 1);
        rst = 1'b1;
        mq0.delete(); mq1.delete();
        #1;
        chk("midrst_gnt", bus.gnt_o, 0);
        chk("midrst_ena", vram_ena, 0);
        chk("midrst_busy", busy, 0);
        chk_wlog("midrst_before", {200});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        add(0, 0, 210, 1, 1);
        add(1, 0, 220, 0, 1);
        wait_drain("midrst_after", 200);
        chk_glog("midrst_after", {0, 1}, {1, 1});
        chk_wlog("midrst_after", {210, 220});

        // random traffic against the model
        do_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 400; i++) begin
                int r;
                int a;
                r = int'($urandom_range(0, 9));
                if ($urandom_range(0, 15) == 0) a = FRAME + int'($urandom_range(0, (1 << AW) - 1 - FRAME));
                else a = int'($urandom_range(0, FRAME - 1));
                add(m, (r == 0), a, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            end
        end
        wait_drain("random", 20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Shares the single VRAM write port between two write masters: the frame copy engine (requester 0, RAM→VRAM at frame end) and the brush painter (requester 1, user-placed sand cells). Arbitration uses request/grant handshakes with bounded bursts, so neither master can starve the other. Writes are registered onto the VRAM write port. The block sits between the game state controller's copy path and the VRAM.

## Interface
- ACTIVE_COLUMNS, 640, frame width in cells
- ACTIVE_ROWS, 480, frame height in cells
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), VRAM address width
- DATA_WIDTH, 1, cell state width
- MAX_BURST, 64, maximum accepted beats per grant; must be ≥ 1
- clk_i  in  1  system clock
- reset_i  in  1  reset; asynchronous, active-high
- req_i  in  2  per-requester write request; bit 0 = copy engine, bit 1 = brush
- last_i  in  2  per-requester final-beat flag; sampled only with req_i and gnt_o
- addr0_i, addr1_i  in  ADDR_WIDTH each  write address per requester
- data0_i, data1_i  in  DATA_WIDTH each  write data per requester
- gnt_o  out  2  one-hot grant (or 0)
- vram_write_address_o  out  ADDR_WIDTH  registered VRAM write address
- vram_write_data_o  out  DATA_WIDTH  registered VRAM write data
- vram_write_ena_o  out  1  registered VRAM write enable
- oor_o  out  1  one-cycle pulse: an accepted beat had address ≥ ACTIVE_COLUMNS*ACTIVE_ROWS
- busy_o  out  1  high while any grant is held

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Round-robin pointer `prio` names the requester preferred on a tie.
- IDLE: if exactly one req_i bit is set, grant that requester. If both are set, grant `prio`. Otherwise stay in IDLE.
- Beat: a cycle with gnt_o[k] & req_i[k]. Each beat is accepted: its address and data are registered, and the burst counter increments.
- Release of requester k happens on any of:
  - an accepted beat with last_i[k] set;
  - req_i[k] low while granted (a zero-beat release is allowed);
  - the accepted beat that makes the burst counter reach MAX_BURST (forced release).
- On release: `prio` moves to the other requester, and the burst counter clears.
  - If the other requester's req is high in the release cycle, go directly to its GRANT state (no idle gap).
  - Otherwise, go to IDLE.
- Forced-release requester k keeps req_i[k] high. It is re-granted when its turn comes, or immediately if the other requester is idle.
- Out-of-range beat (addr ≥ ACTIVE_COLUMNS*ACTIVE_ROWS): it still counts as a beat, vram_write_ena_o stays low for it, and oor_o pulses.
- Burst counter width is $clog2(MAX_BURST+1) and never wraps.
- busy_o = |gnt_o.

## Timing
- Reset values: all outputs 0, state IDLE, prio = 0, burst counter = 0. Assertion is asynchronous and clears outputs immediately, including mid-burst. Write data in flight is dropped.
- Request to grant: req_i rises in cycle N while IDLE → gnt_o valid in cycle N+1.
- Write latency: beat accepted in cycle M → vram_write_* and oor_o valid in cycle M+1, for exactly one cycle.
- Release beat in cycle M → gnt_o[k] low in M+1. In the same cycle M+1, gnt_o for the other requester is high if it was waiting.
- Back-to-back throughput: one beat per cycle within a grant. The handover between requesters costs 0 cycles.
- gnt_o is registered (state-derived) and never combinationally dependent on req_i.

## Configuration
- VRAM_ARB_FIXED_PRIO_EN defined: `prio` is fixed at 0. The copy engine always wins ties, and forced release still applies, so the brush still progresses after each MAX_BURST window.
- Undefined (default): round-robin as described above.

## Test plan
- Single requester: req_i=01, 4 beats at addr 0..3, data 1, last on beat 4.
  - Required: gnt_o=01 one cycle after req.
  - Required: vram_write_ena_o high for 4 cycles with addr 0..3 at +1 cycle.
  - Required: gnt_o=00 after the last beat.
- Simultaneous requests from reset: req_i=11.
  - Required: requester 0 granted first.
  - Required: after its last beat, gnt_o=10 the next cycle with no idle cycle.
  - Required: a subsequent 11 tie goes to 0 only after 1 has been served.
- Forced release with MAX_BURST=4: requester 0 streams 10 beats with no last, while requester 1 waits.
  - Required: grant order 0(4 beats), 1, 0(4), 1, 0(2).
  - Required: exactly 10 writes with requester 0's addresses, in order.
- Out-of-range: beat at addr 307200 → vram_write_ena_o=0 and oor_o=1 for one cycle; the next in-range beat writes normally.
- Reset mid-burst: assert reset_i during beat 3 of 5.
  - Required: gnt_o, vram_write_ena_o and busy_o are 0 in the same cycle.
  - Required: after release, a new request is granted per the reset-state prio=0.
- With VRAM_ARB_FIXED_PRIO_EN: repeated 11 ties always grant requester 0 first; requester 1 is granted only after each forced or last release.
